// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-port bundle for mem_access_unit.
// The slave modport is the unit; the master modport is the MEM stage plus RAM.
interface mem_access_unit_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] ram_address;
   logic [31:0]       ram_data_write;
   logic              ram_write_en;
   logic              ram_read_en;
   logic [31:0]       ram_data_in;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_data_in,
      output req_ready, resp_valid, resp_rdata, resp_err, ram_address, ram_data_write,
             ram_write_en, ram_read_en
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_data_in,
      input  req_ready, resp_valid, resp_rdata, resp_err, ram_address, ram_data_write,
             ram_write_en, ram_read_en
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end: sub-word loads/stores onto a word-only RAM via read-modify-write.
// Define MAU_ALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module mem_access_unit #(
   parameter int unsigned INIT_CYCLES = 1,
   parameter int unsigned ADDR_W      = 32
) (
   input logic              clk,
   input logic              reset,
   mem_access_unit_if.slave bus
);

   typedef enum logic [2:0] {StInit, StIdle, StRead, StWrite, StResp} state_e;

   localparam int unsigned     CntW    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(INIT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              we_q, unsigned_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q, addr_in;
   logic [31:0]       wdata_q, word_q, merged, extended;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic              accept, trap, err;
   logic              in_read, in_write, in_resp;

   assign accept   = (state_q == StIdle) && bus.req_valid;
   assign in_read  = (state_q == StRead);
   assign in_write = (state_q == StWrite);
   assign in_resp  = (state_q == StResp);

   // Misaligned low bits are dropped; with the trap enabled such requests never reach the RAM.
   always_comb begin
      addr_in = bus.req_addr;
      if (bus.req_size == 2'b01) addr_in[0] = 1'b0;
      else if (bus.req_size[1])  addr_in[1:0] = 2'b00;
   end

`ifdef MAU_ALIGN_TRAP_EN
   logic misalign, err_q;
   assign misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      err_q <= 1'b0;
      else if (accept) err_q <= misalign;
   end

   assign trap = misalign;
   assign err  = err_q;
`else
   assign trap = 1'b0;
   assign err  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StInit: begin
            if (cnt_q == CntLast) state_d = StIdle;
            else                  cnt_d   = cnt_q + 1'b1;
         end
         StIdle: begin
            if (bus.req_valid) begin
               if (trap)                             state_d = StResp;
               else if (bus.req_we && bus.req_size[1]) state_d = StWrite;
               else                                  state_d = StRead;
            end
         end
         StRead:  state_d = we_q ? StWrite : StResp;
         StWrite: state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StInit;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q       <= bus.req_we;
            size_q     <= bus.req_size;
            unsigned_q <= bus.req_unsigned;
            addr_q     <= addr_in;
            wdata_q    <= bus.req_wdata;
         end
         if (in_read) word_q <= bus.ram_data_in;
      end
   end

   assign byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
   assign half_sel = word_q[{addr_q[1], 4'b0000} +: 16];

   // Same lane decode serves the store merge and the load extension.
   always_comb begin
      merged   = word_q;
      extended = word_q;
      case (size_q)
         2'b00: begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            extended = {{24{byte_sel[7] & ~unsigned_q}}, byte_sel};
         end
         2'b01: begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            extended = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
         end
         default: merged = wdata_q;
      endcase
   end

   assign bus.req_ready      = (state_q == StIdle);
   assign bus.ram_read_en    = in_read;
   assign bus.ram_write_en   = in_write;
   assign bus.resp_valid     = in_resp;
   assign bus.ram_address    = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.ram_data_write = in_write ? merged : 32'h0;
   assign bus.resp_rdata     = (in_resp && !we_q && !err) ? extended : 32'h0;
   assign bus.resp_err       = in_resp & err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded random + directed bench for mem_access_unit against a byte-lane reference model.
module tb_mem_access_unit;

   localparam int unsigned INIT_CYCLES = 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          accept;
      int          reads;
      int          writes;
      logic [31:0] waddr;
      logic [31:0] wdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   bit          mon_en = 1'b1;
   exp_t        sbq[$];
   logic [31:0] model_mem[16];
   logic [31:0] ram[16];
   logic        pre_en = 1'b0;
   logic [3:0]  pre_idx = '0;
   logic [31:0] pre_val = '0;

   mem_access_unit_if #(.ADDR_W(32)) bus ();

   mem_access_unit #(.INIT_CYCLES(INIT_CYCLES), .ADDR_W(32)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural RAM: combinational read, write on the strobed edge.
   assign bus.ram_data_in = ram[bus.ram_address[5:2]];
   always @(posedge clk) begin
      if (pre_en)                ram[pre_idx] <= pre_val;
      else if (bus.ram_write_en) ram[bus.ram_address[5:2]] <= bus.ram_data_write;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(negedge clk);
      pre_en = 1'b0;
      model_mem[idx] = val;
   endtask

   function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata, input int acc);
      exp_t        e;
      int          k;
      int          idx;
      logic [31:0] w, mask, v;
      bit          is_word, is_half, mis;
      is_word = (size >= 2);
      is_half = (size == 1);
      mis     = (is_half && addr[0]) || (is_word && (addr % 4 != 0));
      e.accept = acc; e.rdata = 0; e.err = 0; e.reads = 0; e.writes = 0;
      e.waddr = addr & 32'hFFFF_FFFC; e.wdata = 0;
`ifdef MAU_ALIGN_TRAP_EN
      if (mis) begin
         e.err = 1; e.lat = 1;
         return e;
      end
`endif
      if (mis) e.lat = 0;
      idx = int'(addr[5:2]);
      w   = model_mem[idx];
      k   = is_word ? 0 : (is_half ? int'(addr[1]) * 2 : int'(addr[1:0]));
      if (!we) begin
         e.reads = 1; e.lat = 2;
         if (is_word) e.rdata = w;
         else if (is_half) begin
            v = (w >> (8 * k)) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
            e.rdata = v;
         end else begin
            v = (w >> (8 * k)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            e.rdata = v;
         end
      end else begin
         e.writes = 1;
         if (is_word) begin
            e.lat = 2; e.wdata = wdata;
         end else begin
            e.reads = 1; e.lat = 3;
            mask = (is_half ? 32'hFFFF : 32'hFF) << (8 * k);
            e.wdata = (w & ~mask) | ((wdata << (8 * k)) & mask);
         end
         model_mem[idx] = e.wdata;
      end
      return e;
   endfunction

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit track);
      int n;
      @(negedge clk);
      bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
      bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) check("accept_timeout", 32'd0, 32'd1);
      else if (track) sbq.push_back(model(we, size, uns, addr, wdata, cyc));
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         check("drain_timeout", 32'(sbq.size()), 32'd0);
         sbq.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: counts strobes per transaction and checks each response against the queue head.
   always @(negedge clk) begin
      if (mon_en && reset) begin
         if (bus.ram_read_en) begin
            rd_cnt++;
            if (sbq.size() != 0) check("read_addr", bus.ram_address, sbq[0].waddr);
         end
         if (bus.ram_write_en) begin
            wr_cnt++;
            if (sbq.size() == 0) check("spurious_write", 32'd1, 32'd0);
            else begin
               check("write_addr", bus.ram_address, sbq[0].waddr);
               check("write_data", bus.ram_data_write, sbq[0].wdata);
            end
         end
         if (bus.resp_valid) begin
            if (sbq.size() == 0) check("spurious_resp", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = sbq.pop_front();
               check("resp_rdata", bus.resp_rdata, e.rdata);
               check("resp_err", 32'(bus.resp_err), 32'(e.err));
               check("latency", 32'(cyc - e.accept), 32'(e.lat));
               check("read_strobes", 32'(rd_cnt), 32'(e.reads));
               check("write_strobes", 32'(wr_cnt), 32'(e.writes));
            end
            rd_cnt = 0;
            wr_cnt = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
      bus.req_addr = '0; bus.req_wdata = '0;
      #2;
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_resp_err", 32'(bus.resp_err), 32'd0);
      check("rst_ram_address", bus.ram_address, 32'd0);
      check("rst_ram_data_write", bus.ram_data_write, 32'd0);
      check("rst_ram_write_en", 32'(bus.ram_write_en), 32'd0);
      check("rst_ram_read_en", 32'(bus.ram_read_en), 32'd0);
      for (int i = 0; i < 16; i++) preload(4'(i), $urandom);

      // T1: request already waiting when reset releases.
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < int'(INIT_CYCLES); i++) begin
         #1;
         check("init_ready", 32'(bus.req_ready), 32'd0);
         check("init_strobes", 32'({bus.ram_read_en, bus.ram_write_en}), 32'd0);
         @(negedge clk);
      end
      check("init_done_ready", 32'(bus.req_ready), 32'd1);
      if (bus.req_ready) sbq.push_back(model(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, cyc));
      @(negedge clk);
      bus.req_valid = 1'b0;
      drain();

      // T2: load extension on 0x0000F1E0.
      preload(4'd4, 32'h0000_F1E0);
      issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b1);
      issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b1);
      issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b1);
      issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1);
      drain();

      // T3: byte store read-modify-write, then read back.
      preload(4'd1, 32'h1122_3344);
      issue(1'b1, 2'b00, 1'b0, 32'h05, 32'h0000_00AB, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b1);
      drain();
      check("t3_ram_word", ram[1], 32'h1122_AB44);

      // T4: word store skips the read.
      issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hFFFF_FFD9, 1'b1);
      drain();
      check("t4_ram_word", ram[2], 32'hFFFF_FFD9);

      // T5: aligned and misaligned half stores.
      preload(4'd3, 32'h0000_7D00);
      issue(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_BEEF, 1'b1);
      drain();
      check("t5_aligned_half", ram[3], 32'hBEEF_7D00);
      preload(4'd3, 32'h0000_7D00);
      issue(1'b1, 2'b01, 1'b0, 32'h0D, 32'h0000_BEEF, 1'b1);
      drain();
`ifdef MAU_ALIGN_TRAP_EN
      check("t5_misaligned_half", ram[3], 32'h0000_7D00);
`else
      check("t5_misaligned_half", ram[3], 32'h0000_BEEF);
`endif

      // Randomised traffic over a 16-word window.
      for (int i = 0; i < 300; i++) begin
         issue(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 63)),
               $urandom, 1'b1);
      end
      drain();
      for (int i = 0; i < 16; i++) check("final_ram_word", ram[i], model_mem[i]);

      // T6: reset lands in the WRITE cycle of a byte store.
      preload(4'd2, 32'h5566_7788);
      mon_en = 1'b0;
      issue(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_0012, 1'b0);
      begin
         int n;
         n = 0;
         while (!bus.ram_write_en && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      check("t6_reached_write", 32'(bus.ram_write_en), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("t6_write_en_drop", 32'(bus.ram_write_en), 32'd0);
      check("t6_resp_valid", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t6_init_ready", 32'(bus.req_ready), 32'd0);
      check("t6_ram_unchanged", ram[2], 32'h5566_7788);
      rd_cnt = 0;
      wr_cnt = 0;
      mon_en = 1'b1;
      issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
